// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage: default encodings, the PC-source
// select used by the priority mux, and the IF/ID register layout.
package if_id_stage_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam int          DEF_CNT_W     = 16;

  // PCSRC_SEQ must stay 2'b00 so that an idle select means sequential fetch
  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_HOLD   = 2'b01,
    PCSRC_TARGET = 2'b10,
    PCSRC_PEND   = 2'b11
  } pcsrc_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-stage bus: hazard inputs from ID/EX/memory, the instruction-memory
// port, the IF/ID register outputs and the debug counters.
interface if_id_stage_if #(
  parameter int CNT_W = 16
);
  logic             in_data_hazard;
  logic             in_ctrl_hazard;
  logic [31:0]      in_target_pc;
  logic             in_mem_stall;
  logic [31:0]      out_imem_addr;
  logic [31:0]      in_imem_instr;
  logic [31:0]      out_IFID_instr;
  logic [31:0]      out_IFID_pc4;
  logic             out_IFID_valid;
  logic [CNT_W-1:0] out_stall_cnt;
  logic [CNT_W-1:0] out_flush_cnt;

  // master is the fetch stage itself; slave is the surrounding core/memory
  modport master (
    input  in_data_hazard, in_ctrl_hazard, in_target_pc, in_mem_stall, in_imem_instr,
    output out_imem_addr, out_IFID_instr, out_IFID_pc4, out_IFID_valid,
           out_stall_cnt, out_flush_cnt
  );

  modport slave (
    output in_data_hazard, in_ctrl_hazard, in_target_pc, in_mem_stall, in_imem_instr,
    input  out_imem_addr, out_IFID_instr, out_IFID_pc4, out_IFID_valid,
           out_stall_cnt, out_flush_cnt
  );
endinterface

// File: rtl/if_id_stage_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long debug
// session never reports a misleadingly small count.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF stage and IF/ID pipeline register: owns the PC, applies stalls and
// redirects, and registers {instr, PC+4, valid} for decode.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter int          CNT_W     = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst_n,
  if_id_stage_if.master bus
);

  logic [31:0]      pc;
  logic [31:0]      pend_pc;
  logic             pend_valid;
  ifid_t            ifid;
  pcsrc_e           pc_src;
  logic             stall_inc;
  logic             flush_inc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Memory stall beats everything; a redirect (live or pending) beats load-use
  always_comb begin
    pc_src    = PCSRC_SEQ;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (bus.in_mem_stall) begin
      pc_src    = PCSRC_HOLD;
      stall_inc = 1'b1;
    end else if (bus.in_ctrl_hazard) begin
      pc_src    = PCSRC_TARGET;
      flush_inc = 1'b1;
    end else if (pend_valid) begin
      pc_src    = PCSRC_PEND;
      flush_inc = 1'b1;
    end else if (bus.in_data_hazard) begin
      pc_src    = PCSRC_HOLD;
      stall_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (pc_src)
        PCSRC_SEQ:    pc <= pc_plus4(pc);
        PCSRC_TARGET: pc <= bus.in_target_pc;
        PCSRC_PEND:   pc <= pend_pc;
        default:      pc <= pc;
      endcase
    end
  end

  // A bubble keeps the old pc4 so ID still sees a stable value on the squashed slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid.instr <= NOP_INSTR;
      ifid.pc4   <= 32'h0000_0000;
      ifid.valid <= 1'b0;
    end else begin
      case (pc_src)
        PCSRC_SEQ: begin
          ifid.instr <= bus.in_imem_instr;
          ifid.pc4   <= pc_plus4(pc);
          ifid.valid <= 1'b1;
        end
        PCSRC_TARGET, PCSRC_PEND: begin
          ifid.instr <= NOP_INSTR;
          ifid.valid <= 1'b0;
        end
        default: begin
          ifid <= ifid;
        end
      endcase
    end
  end

  // A redirect arriving during a freeze is parked here and applied on the first free cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0000_0000;
    end else if (bus.in_mem_stall) begin
      if (bus.in_ctrl_hazard) begin
        pend_valid <= 1'b1;
        pend_pc    <= bus.in_target_pc;
      end
    end else begin
      pend_valid <= 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign bus.out_imem_addr  = pc;
  assign bus.out_IFID_instr = ifid.instr;
  assign bus.out_IFID_pc4   = ifid.pc4;
  assign bus.out_IFID_valid = ifid.valid;
  assign bus.out_stall_cnt  = stall_cnt;
  assign bus.out_flush_cnt  = flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios with literal expectations plus a
// randomized phase, all compared each cycle against a behavioural fetch model.
module tb_if_id_stage;

  localparam int          CNT_W    = 5;
  localparam logic [31:0] CNT_MAX  = 32'd31;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] IMEM_TAG = 32'h0000_A000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  if_id_stage_if #(.CNT_W(CNT_W)) bus ();

  if_id_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory: every word reads back as its own address tagged with 0xA000
  assign bus.in_imem_instr = bus.out_imem_addr | IMEM_TAG;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the fetch stage
  logic [31:0] m_pc, m_instr, m_pc4, m_pend_pc, m_stall, m_flush;
  logic        m_valid, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
      m_pend = 1'b0; m_pend_pc = 32'h0; m_stall = 32'h0; m_flush = 32'h0;
    end else if (bus.in_mem_stall) begin
      if (m_stall < CNT_MAX) m_stall = m_stall + 1;
      if (bus.in_ctrl_hazard) begin
        m_pend = 1'b1;
        m_pend_pc = bus.in_target_pc;
      end
    end else if (bus.in_ctrl_hazard || m_pend) begin
      m_pc = bus.in_ctrl_hazard ? bus.in_target_pc : m_pend_pc;
      m_instr = NOP;
      m_valid = 1'b0;
      m_pend = 1'b0;
      if (m_flush < CNT_MAX) m_flush = m_flush + 1;
    end else if (bus.in_data_hazard) begin
      if (m_stall < CNT_MAX) m_stall = m_stall + 1;
    end else begin
      m_instr = m_pc | IMEM_TAG;
      m_pc = m_pc + 32'd4;
      m_pc4 = m_pc;
      m_valid = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    else
      n_pass++;
  endtask

  task automatic applyStimulus(input logic dh, input logic ch, input logic [31:0] tgt, input logic ms);
    bus.in_data_hazard = dh;
    bus.in_ctrl_hazard = ch;
    bus.in_target_pc   = tgt;
    bus.in_mem_stall   = ms;
  endtask

  // Continuous compare of every output against the model, away from the active edge
  always @(negedge clk) begin
    checkOutput("pc",    bus.out_imem_addr,              m_pc);
    checkOutput("instr", bus.out_IFID_instr,             m_instr);
    checkOutput("pc4",   bus.out_IFID_pc4,               m_pc4);
    checkOutput("valid", {31'h0, bus.out_IFID_valid},    {31'h0, m_valid});
    checkOutput("stall", 32'(bus.out_stall_cnt),         m_stall);
    checkOutput("flush", 32'(bus.out_flush_cnt),         m_flush);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_pc", bus.out_imem_addr, 32'h0);
    checkOutput("rst_valid", {31'h0, bus.out_IFID_valid}, 32'h0);
    checkOutput("rst_cnt", 32'(bus.out_stall_cnt) + 32'(bus.out_flush_cnt), 32'h0);
    rst_n = 1'b1;

    // Free run from reset
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("t1_pc4", bus.out_IFID_pc4, 32'(4 * k));
      checkOutput("t1_instr", bus.out_IFID_instr, IMEM_TAG + 32'(4 * (k - 1)));
      checkOutput("t1_valid", {31'h0, bus.out_IFID_valid}, 32'h1);
    end
    checkOutput("pin_model_pc", m_pc, 32'h10);

    // Load-use stall for two cycles
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("t2_pc_hold", bus.out_imem_addr, 32'h10);
      checkOutput("t2_pc4_hold", bus.out_IFID_pc4, 32'h10);
    end
    checkOutput("t2_stall", 32'(bus.out_stall_cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t2_resume_pc", bus.out_imem_addr, 32'h14);
    checkOutput("t2_resume_instr", bus.out_IFID_instr, 32'h0000_A010);
    repeat (3) @(negedge clk);
    checkOutput("t3_pc_start", bus.out_imem_addr, 32'h20);

    // Taken branch from 0x20 to 0x100
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
    @(negedge clk);
    checkOutput("t3_pc", bus.out_imem_addr, 32'h100);
    checkOutput("t3_bubble", {31'h0, bus.out_IFID_valid}, 32'h0);
    checkOutput("t3_bubble_pc4", bus.out_IFID_pc4, 32'h20);
    checkOutput("t3_flush", 32'(bus.out_flush_cnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t3_target_instr", bus.out_IFID_instr, 32'h0000_A100);
    checkOutput("t3_target_pc4", bus.out_IFID_pc4, 32'h104);
    checkOutput("pin_model_valid", {31'h0, m_valid}, 32'h1);

    // Redirect and load-use together: redirect wins
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0);
    @(negedge clk);
    checkOutput("t4_pc", bus.out_imem_addr, 32'h300);
    checkOutput("t4_bubble", {31'h0, bus.out_IFID_valid}, 32'h0);
    checkOutput("t4_stall", 32'(bus.out_stall_cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t4_next_pc", bus.out_imem_addr, 32'h304);

    // Memory stall for three cycles with a redirect captured in the middle
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t5_pc_hold", bus.out_imem_addr, 32'h304);
    checkOutput("t5_stall", 32'(bus.out_stall_cnt), 32'd5);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t5_pc", bus.out_imem_addr, 32'h200);
    checkOutput("t5_bubble", {31'h0, bus.out_IFID_valid}, 32'h0);
    checkOutput("t5_flush", 32'(bus.out_flush_cnt), 32'd3);
    @(negedge clk);
    checkOutput("t5_target_pc4", bus.out_IFID_pc4, 32'h204);

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t6_wrap_pc", bus.out_imem_addr, 32'h0);
    checkOutput("t6_wrap_pc4", bus.out_IFID_pc4, 32'h0);
    checkOutput("t6_wrap_instr", bus.out_IFID_instr, 32'hFFFF_FFFC);

    // Counter saturation
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("t6_stall_sat", 32'(bus.out_stall_cnt), CNT_MAX);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("t6_flush_sat", 32'(bus.out_flush_cnt), CNT_MAX);
    checkOutput("pin_model_flush", m_flush, CNT_MAX);

    // Reset in the middle of a stall with a redirect parked
    applyStimulus(1'b0, 1'b1, 32'h400, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkOutput("t6_async_rst_pc", bus.out_imem_addr, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_no_redirect_pc", bus.out_imem_addr, 32'h4);
    checkOutput("t6_no_redirect_valid", {31'h0, bus.out_IFID_valid}, 32'h1);
    checkOutput("t6_cnt_cleared", 32'(bus.out_flush_cnt), 32'h0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, tgt,
                    $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
